// File: rtl/dir_rom_pkg.sv
// Shared types and helpers for the direction-ROM arbiter.
package dir_rom_pkg;

    localparam int unsigned DIR_ADDR_W  = 8;
    localparam int unsigned DIR_DATA_W  = 5;
    localparam int unsigned DIR_MAX_REQ = 8;
    localparam int unsigned DIR_IDX_W   = $clog2(DIR_MAX_REQ);
    localparam int unsigned DIR_BUS_W   = DIR_MAX_REQ * DIR_ADDR_W;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Picks requester idx's address out of a packed address bus.
    function automatic logic [DIR_ADDR_W-1:0] addr_slice(
        input logic [DIR_BUS_W-1:0] addr_bus,
        input logic [DIR_IDX_W-1:0] idx
    );
        return addr_bus[32'(idx) * DIR_ADDR_W +: DIR_ADDR_W];
    endfunction

endpackage

// File: rtl/dir_rom_arbiter_rr.sv
// Round-robin priority search: first valid index at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int unsigned cand;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            // ptr < N always, so one subtraction handles the wrap for any N
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && valid[IDX_W'(cand)]) begin
                found                  = 1'b1;
                grant[IDX_W'(cand)]    = 1'b1;
                grant_idx              = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/dir_rom_arbiter.sv
// Shares one combinational direction ROM among NUM_REQ requesters with
// round-robin arbitration, capped burst lock and a two-stage response pipe.
module dir_rom_arbiter
    import dir_rom_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADDR_W    = DIR_ADDR_W,
    parameter int unsigned DATA_W    = DIR_DATA_W,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0]         rom_a,
    input  logic [DATA_W-1:0]         rom_spo
);

    localparam int unsigned PTR_W    = $clog2(NUM_REQ);
    localparam int unsigned BCNT_W   = $clog2(MAX_BURST) + 1;
    localparam int unsigned LAST_IDX = NUM_REQ - 1;

    arb_state_e                state_q, state_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [PTR_W-1:0]          owner_q, owner_d;
    logic [BCNT_W-1:0]         burst_cnt_q, burst_cnt_d;
    logic                      s1_v_q, s1_v_d;
    logic [PTR_W-1:0]          tag_q, tag_d;
    logic [ADDR_W-1:0]         rom_a_q, rom_a_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]        arb_valid;
    logic [NUM_REQ-1:0]        gnt;
    logic [PTR_W-1:0]          gnt_idx;
    logic                      xfer;
    logic [DIR_BUS_W-1:0]      addr_bus;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (32'(i) == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // Address slicing uses the package width; ADDR_W is expected to match it.
    assign addr_bus = DIR_BUS_W'(req_addr);

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_rr (
        .valid     (arb_valid),
        .ptr       (ptr_q),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            s1_v_q      <= 1'b0;
            tag_q       <= '0;
            rom_a_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            s1_v_q      <= s1_v_d;
            tag_q       <= tag_d;
            rom_a_q     <= rom_a_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Lock FSM, burst counter and round-robin pointer update.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (xfer) begin
                    if (req_lock[gnt_idx]) begin
                        state_d     = ARB_LOCKED;
                        owner_d     = gnt_idx;
                        burst_cnt_d = BCNT_W'(1);
                    end else begin
                        ptr_d = next_idx(gnt_idx);
                    end
                end
            end
            ARB_LOCKED: begin
                if (!req_valid[owner_q]) begin
                    state_d     = ARB_IDLE;
                    ptr_d       = next_idx(owner_q);
                    burst_cnt_d = '0;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (!req_lock[owner_q] || burst_cnt_d == BCNT_W'(MAX_BURST)) begin
                        state_d     = ARB_IDLE;
                        ptr_d       = next_idx(owner_q);
                        burst_cnt_d = '0;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant masking and the two-stage lookup/response pipeline.
    always_comb begin
        arb_valid = '0;
        if (!rst) begin
            if (state_q == ARB_LOCKED) begin
                arb_valid = req_valid & (NUM_REQ'(1) << owner_q);
            end else begin
                arb_valid = req_valid;
            end
        end
        s1_v_d  = xfer;
        tag_d   = tag_q;
        rom_a_d = rom_a_q;
        if (xfer) begin
            tag_d   = gnt_idx;
            rom_a_d = ADDR_W'(addr_slice(addr_bus, DIR_IDX_W'(gnt_idx)));
        end
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (s1_v_q) begin
            rsp_valid_d[tag_q]                       = 1'b1;
            rsp_data_d[32'(tag_q) * DATA_W +: DATA_W] = rom_spo;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rom_a     = rom_a_q;

endmodule

// File: doc/dir_rom_arbiter.md
# dir_rom_arbiter

- Shares one combinational direction ROM (8-bit address, 5-bit bin data) among NUM_REQ descriptor/orientation requesters.
- Arbitration is round-robin, with an optional capped burst lock so a requester can sweep a row of entries without interleaving.
- Each granted lookup returns to its requester as a registered one-cycle response pulse.
- Sits between the per-lane descriptor sequencers and the single ROM instance.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, ROM address width
- DATA_W, 5, ROM data width
- MAX_BURST, 16, maximum consecutive grants under lock (power of two, 2..256)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester lookup request
- req_lock  in  NUM_REQ  requester asks to keep the grant next cycle
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant; combinational from req_valid and arbiter state
- rsp_valid  out  NUM_REQ  one-cycle response pulse, registered
- rsp_data  out  NUM_REQ*DATA_W  packed response data; holds its value until the next response to that requester
- rom_a  out  ADDR_W  registered ROM address
- rom_spo  in  DATA_W  ROM data, combinational from rom_a

## Operation
- **Handshake:** transfer on req_valid[i] & req_ready[i]. At most one req_ready bit is high per cycle. req_ready is 0 for any requester with req_valid low.
- **Round-robin:** ptr (log2 NUM_REQ bits) names the highest-priority index. Search ptr, ptr+1, … mod NUM_REQ; the first valid requester wins. After an unlocked grant to k, ptr <= (k+1) mod NUM_REQ.
- **Lock state machine**, states IDLE and LOCKED:
  - IDLE → LOCKED on a transfer from k with req_lock[k]=1. Set owner=k, burst_cnt=1.
  - In LOCKED, only owner may be granted, regardless of ptr.
  - Each owner transfer increments burst_cnt.
  - LOCKED → IDLE when any of these happens:
    - the owner transfers with req_lock=0;
    - the owner drops req_valid;
    - burst_cnt reaches MAX_BURST on a transfer.
  - On LOCKED → IDLE, ptr <= owner+1. Any other requester may win the arbitration in the same cycle the FSM returns to IDLE only from the following cycle (an exit cycle without a transfer is a bubble).
- **Pipeline:**
  - Stage 1: on transfer, rom_a <= req_addr[k] and tag <= k, s1_v <= 1.
  - Stage 2: when s1_v, rsp_data[tag] <= rom_spo and rsp_valid[tag] <= 1 for one cycle.
  - No response backpressure: requesters must sink every pulse.
- **Idle behaviour:** rom_a holds its last value when no transfer occurs.
- **Widths:** burst_cnt is log2(MAX_BURST)+1 bits. ptr wraps modulo NUM_REQ, including non-power-of-two NUM_REQ.

## Timing
- Transfer in cycle T → rom_a valid from edge T+1 → rsp_valid pulse in cycle T+2. Latency is 2, throughput is 1 lookup per cycle.
- **Reset values:** ptr=0, FSM=IDLE, burst_cnt=0, s1_v=0, rom_a=0, rsp_valid=0, rsp_data=0.
- **Reset mid-operation:** in-flight stage-1 lookups are dropped and no rsp_valid appears after the reset cycle. A lock in progress is cancelled.
- **Simultaneous requests:** when all requesters are valid every cycle with lock low, grants rotate 0,1,2,3,0,…
- **Single requester:** a lone valid requester is granted every cycle.
- **Same requester back-to-back:** two transfers from the same requester produce consecutive rsp_valid pulses, in order.

## Structure
- Shared package dir_rom_pkg holds:
  - DIR_ADDR_W=8 and DIR_DATA_W=5;
  - the FSM state enum (ARB_IDLE, ARB_LOCKED);
  - a function that extracts the packed address slice.
- One sub-module, rr_arbiter: takes the valid vector and ptr, produces a one-hot grant and the encoded index.
- The lock FSM, burst counter and response pipeline live in dir_rom_arbiter.
- The bench instantiates the real ROM on rom_a/rom_spo.

## Test plan
- **Reset:** rst high for 2 cycles with all requests valid → req_ready=0 during reset, all outputs zero; the first grant after release goes to requester 0.
- **Single lookup:** requester 2 requests address 0x00 at T → rom_a=0x00 at T+1, rsp_valid=4'b0100 at T+2, rsp_data[2]=0x0A.
- **Round-robin fairness:** all four valid for 8 cycles, lock low, addresses 0x0C/0xFF/0x8F/0x01 → grant order 0,1,2,3,0,1,2,3. Responses are 0x1F, 0x17, 0x19, 0x09, each two cycles after its grant.
- **Burst lock:** requester 1 locks, sweeping addresses 0x10..0x1F while the others stay valid → 16 consecutive grants to 1. The lock is released by the MAX_BURST cap, and the next grant goes to 2.
- **Early unlock:** owner 3 drops req_valid while locked → FSM returns to IDLE, ptr becomes 0, and requester 0 is granted the next cycle.
- **Mid-flight reset:** rst is asserted in the cycle after a transfer → no rsp_valid follows, and ptr returns to 0.
